// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the tournament branch predictor.
// Counter widths up to CTR_W_MAX bits are supported by the helpers.
package bp_pkg;

  typedef enum logic {INIT, READY} bpState_e;

  localparam int CTR_W_MAX = 8;

  // Weak value just below the taken/global midpoint: 0 followed by all ones.
  function automatic logic [CTR_W_MAX-1:0] weakLow(input int bits);
    return CTR_W_MAX'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] satStep(
    input logic [CTR_W_MAX-1:0] cur,
    input logic                 inc,
    input logic                 dec,
    input int                   bits
  );
    logic [CTR_W_MAX-1:0] ctrMax;
    ctrMax = CTR_W_MAX'((1 << bits) - 1);
    if (inc && (cur != ctrMax)) return cur + CTR_W_MAX'(1);
    if (dec && (cur != '0))     return cur - CTR_W_MAX'(1);
    return cur;
  endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Array of saturating counters: one async read port, one read-modify-write
// update port, and an init-write override used by the post-reset sweep.
module sat_ctr_table
  import bp_pkg::*;
#(
  parameter int                IDX_BITS = 8,
  parameter int                CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] INIT_VAL = '0
)(
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rdIdx,
  output logic [CTR_BITS-1:0] rdCtr,
  input  logic                wrEn,
  input  logic [IDX_BITS-1:0] wrIdx,
  input  logic                wrInc,
  input  logic                wrDec,
  input  logic                initEn,
  input  logic [IDX_BITS-1:0] initIdx
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [CTR_BITS-1:0] mem [DEPTH];
  logic [CTR_BITS-1:0] wrNext;

  assign rdCtr  = mem[rdIdx];
  assign wrNext = CTR_BITS'(satStep(CTR_W_MAX'(mem[wrIdx]), wrInc, wrDec, CTR_BITS));

  always_ff @(posedge clk) begin
    if (initEn) begin
      mem[initIdx] <= INIT_VAL;
    end else if (wrEn) begin
      mem[wrIdx] <= wrNext;
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: local (LHT->LPHT) and gshare components with a
// per-PC chooser, speculative GHR with mispredict repair, post-reset table sweep.
module tournament_predictor
  import bp_pkg::*;
#(
  parameter int GHIST_BITS   = 8,
  parameter int LHT_IDX_BITS = 6,
  parameter int LHIST_BITS   = 6,
  parameter int CTR_BITS     = 2,
  parameter int PC_W         = 32
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req_valid,
  input  logic [PC_W-1:0]       pred_req_pc,
  output logic                  pred_ready,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic                  pred_use_global,
  output logic                  pred_local,
  output logic                  pred_global,
  output logic [GHIST_BITS-1:0] pred_ghist,
  output logic [LHIST_BITS-1:0] pred_lhist,
  input  logic                  upd_valid,
  input  logic [PC_W-1:0]       upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic                  upd_local,
  input  logic                  upd_global,
  input  logic [GHIST_BITS-1:0] upd_ghist,
  input  logic [LHIST_BITS-1:0] upd_lhist,
  output logic                  init_done
);

  localparam int LHT_DEPTH  = 1 << LHT_IDX_BITS;
  localparam int GPHT_DEPTH = 1 << GHIST_BITS;
  localparam int LPHT_DEPTH = 1 << LHIST_BITS;
  localparam int CNT_BITS_A = (GHIST_BITS > LHT_IDX_BITS) ? GHIST_BITS : LHT_IDX_BITS;
  localparam int CNT_BITS   = (CNT_BITS_A > LHIST_BITS) ? CNT_BITS_A : LHIST_BITS;

  localparam logic [CTR_BITS-1:0] WEAK_NT    = CTR_BITS'(weakLow(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_LOCAL = CTR_BITS'(weakLow(CTR_BITS));

  bpState_e            state, stateNext;
  logic [CNT_BITS-1:0] cnt, cntNext;

  logic                  sweeping;
  logic                  lhtInitEn, lphtInitEn, gphtInitEn;
  logic                  updEn, repairEn;
  logic [GHIST_BITS-1:0] ghr;

  logic [LHT_IDX_BITS-1:0] lhtIdx_p0;
  logic [LHIST_BITS-1:0]   lhist_p0;
  logic [GHIST_BITS-1:0]   gIdx_p0;
  logic [CTR_BITS-1:0]     lphtCtr_p0, gphtCtr_p0, chooserCtr_p0;
  logic                    localTaken_p0, globalTaken_p0, useGlobal_p0, taken_p0, fire_p0;

  logic [LHT_IDX_BITS-1:0] updIdx;
  logic [GHIST_BITS-1:0]   updGIdx;
  logic                    chooserInc, chooserDec;

  logic                    vld_p1, taken_p1, useGlobal_p1, localTaken_p1, globalTaken_p1;
  logic [GHIST_BITS-1:0]   ghist_p1;
  logic [LHIST_BITS-1:0]   lhist_p1;

  logic [LHIST_BITS-1:0]   lht [LHT_DEPTH];

  logic unusedBits;
  assign unusedBits = ^{pred_req_pc, upd_pc, lphtCtr_p0, gphtCtr_p0, chooserCtr_p0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The sweep runs to the deepest table; shallower tables stop writing early.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (state == INIT) begin
      cntNext = cnt + 1'b1;
      if (cnt == '1) stateNext = READY;
    end
  end

  assign sweeping   = (state == INIT);
  assign lhtInitEn  = sweeping && (int'(cnt) < LHT_DEPTH);
  assign lphtInitEn = sweeping && (int'(cnt) < LPHT_DEPTH);
  assign gphtInitEn = sweeping && (int'(cnt) < GPHT_DEPTH);
  assign init_done  = (state == READY);

  assign updEn      = (state == READY) && upd_valid;
  assign repairEn   = updEn && upd_mispredict;
  assign pred_ready = (state == READY) && !(upd_valid && upd_mispredict);

  // ---- p0: lookup (async table reads see pre-update contents) ----
  assign fire_p0        = pred_req_valid && pred_ready;
  assign lhtIdx_p0      = pred_req_pc[LHT_IDX_BITS+1:2];
  assign lhist_p0       = lht[lhtIdx_p0];
  assign gIdx_p0        = ghr ^ pred_req_pc[GHIST_BITS+1:2];
  assign localTaken_p0  = lphtCtr_p0[CTR_BITS-1];
  assign globalTaken_p0 = gphtCtr_p0[CTR_BITS-1];
  assign useGlobal_p0   = chooserCtr_p0[CTR_BITS-1];
  assign taken_p0       = useGlobal_p0 ? globalTaken_p0 : localTaken_p0;

  assign updIdx     = upd_pc[LHT_IDX_BITS+1:2];
  assign updGIdx    = upd_ghist ^ upd_pc[GHIST_BITS+1:2];
  assign chooserInc = (upd_global == upd_taken) && (upd_local != upd_taken);
  assign chooserDec = (upd_local == upd_taken) && (upd_global != upd_taken);

  sat_ctr_table #(.IDX_BITS(LHIST_BITS), .CTR_BITS(CTR_BITS), .INIT_VAL(WEAK_NT)) uLpht (
    .clk     (clk),
    .rdIdx   (lhist_p0),
    .rdCtr   (lphtCtr_p0),
    .wrEn    (updEn),
    .wrIdx   (upd_lhist),
    .wrInc   (upd_taken),
    .wrDec   (!upd_taken),
    .initEn  (lphtInitEn),
    .initIdx (cnt[LHIST_BITS-1:0])
  );

  sat_ctr_table #(.IDX_BITS(GHIST_BITS), .CTR_BITS(CTR_BITS), .INIT_VAL(WEAK_NT)) uGpht (
    .clk     (clk),
    .rdIdx   (gIdx_p0),
    .rdCtr   (gphtCtr_p0),
    .wrEn    (updEn),
    .wrIdx   (updGIdx),
    .wrInc   (upd_taken),
    .wrDec   (!upd_taken),
    .initEn  (gphtInitEn),
    .initIdx (cnt[GHIST_BITS-1:0])
  );

  sat_ctr_table #(.IDX_BITS(LHT_IDX_BITS), .CTR_BITS(CTR_BITS), .INIT_VAL(WEAK_LOCAL)) uChooser (
    .clk     (clk),
    .rdIdx   (lhtIdx_p0),
    .rdCtr   (chooserCtr_p0),
    .wrEn    (updEn),
    .wrIdx   (updIdx),
    .wrInc   (chooserInc),
    .wrDec   (chooserDec),
    .initEn  (sweeping && (int'(cnt) < LHT_DEPTH)),
    .initIdx (cnt[LHT_IDX_BITS-1:0])
  );

  always_ff @(posedge clk) begin
    if (lhtInitEn) begin
      lht[cnt[LHT_IDX_BITS-1:0]] <= '0;
    end else if (updEn) begin
      lht[updIdx] <= {upd_lhist[LHIST_BITS-2:0], upd_taken};
    end
  end

  // Repair from the returned snapshot outranks the speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (repairEn) begin
      ghr <= {upd_ghist[GHIST_BITS-2:0], upd_taken};
    end else if (fire_p0) begin
      ghr <= {ghr[GHIST_BITS-2:0], taken_p0};
    end
  end

  // ---- p1: registered prediction ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      taken_p1       <= 1'b0;
      useGlobal_p1   <= 1'b0;
      localTaken_p1  <= 1'b0;
      globalTaken_p1 <= 1'b0;
      ghist_p1       <= '0;
      lhist_p1       <= '0;
    end else begin
      vld_p1 <= fire_p0;
      if (fire_p0) begin
        taken_p1       <= taken_p0;
        useGlobal_p1   <= useGlobal_p0;
        localTaken_p1  <= localTaken_p0;
        globalTaken_p1 <= globalTaken_p0;
        ghist_p1       <= ghr;
        lhist_p1       <= lhist_p0;
      end
    end
  end

  assign pred_valid      = vld_p1;
  assign pred_taken      = taken_p1;
  assign pred_use_global = useGlobal_p1;
  assign pred_local      = localTaken_p1;
  assign pred_global     = globalTaken_p1;
  assign pred_ghist      = ghist_p1;
  assign pred_lhist      = lhist_p1;

endmodule
